uart_cmd_receiver: RTL and testbench

// - Host-command front end, directly upstream of the micro controller unit (MCU) bus master.
// - Deserialises a UART RX line and parses fixed-format frames into single bus commands.
// - Each command carries a write/read flag, an address and 32-bit write data.
// - Presents each command on a valid/ready port; the MCU consumes it and replays it as a USI bus access.

---
 rtl/uart_cmd_receiver_if.sv | 36 +++
 rtl/uart_cmd_receiver.sv | 215 +++++++++++++++++++++
 tb/tb_uart_cmd_receiver.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_receiver_if.sv
// Command port between the UART command receiver and the MCU bus master.
// The receiver (master) drives the command and error pulses; the consumer (slave) drives ready.
interface uart_cmd_receiver_if #(
  parameter int pBusAdrsBit = 16
);
  logic                   oCmdVd;
  logic                   iCmdRdy;
  logic                   oCmdWEd;
  logic [pBusAdrsBit-1:0] oCmdAdrs;
  logic [31:0]            oCmdWd;
  logic                   oFrmErr;
  logic                   oProtErr;
  logic                   oOvfErr;

  modport master (
    output oCmdVd,
    output oCmdWEd,
    output oCmdAdrs,
    output oCmdWd,
    output oFrmErr,
    output oProtErr,
    output oOvfErr,
    input  iCmdRdy
  );

  modport slave (
    input  oCmdVd,
    input  oCmdWEd,
    input  oCmdAdrs,
    input  oCmdWd,
    input  oFrmErr,
    input  oProtErr,
    input  oOvfErr,
    output iCmdRdy
  );
endinterface

// File: rtl/uart_cmd_receiver.sv
// UART RX deserialiser plus frame parser.
// Turns A5-prefixed host frames into single read/write commands on a valid/ready port.
module uart_cmd_receiver #(
  parameter int pSysClkHz   = 100_000_000,
  parameter int pBaudRate   = 115200,
  parameter int pBusAdrsBit = 16,
  parameter int pTimeoutCyc = 1_000_000
) (
  input  logic                iSysClk,
  input  logic                iSysRst,
  input  logic                iUartRx,
  uart_cmd_receiver_if.master cmdBus
);

  localparam int Cpb     = pSysClkHz / pBaudRate;
  localparam int HalfCpb = Cpb / 2;
  localparam int BitCntW = $clog2(Cpb + 1);
  localparam int ToCntW  = $clog2(pTimeoutCyc + 1);

  localparam logic [BitCntW-1:0] cpbLast  = BitCntW'(Cpb - 1);
  localparam logic [BitCntW-1:0] halfLast = BitCntW'(HalfCpb - 1);
  localparam logic [ToCntW-1:0]  toLast   = ToCntW'(pTimeoutCyc - 1);

  localparam logic [3:0] stSync  = 4'd0;
  localparam logic [3:0] stCmd   = 4'd1;
  localparam logic [3:0] stAh    = 4'd2;
  localparam logic [3:0] stAl    = 4'd3;
  localparam logic [3:0] stD3    = 4'd4;
  localparam logic [3:0] stD2    = 4'd5;
  localparam logic [3:0] stD1    = 4'd6;
  localparam logic [3:0] stD0    = 4'd7;
  localparam logic [3:0] stIssue = 4'd8;

  logic               rxMeta;
  logic               rxSync;
  logic               rxPrev;
  logic               rxBusy;
  logic [BitCntW-1:0] rxCnt;
  logic [3:0]         rxBitIdx;
  logic [7:0]         rxShift;
  logic [7:0]         rxByte;
  logic               byteStb;
  logic               frmErr;

  logic [3:0]         state;
  logic               cmdWrite;
  logic [15:0]        adrs;
  logic [31:0]        wData;
  logic               cmdVd;
  logic               protErr;
  logic               ovfErr;
  logic [ToCntW-1:0]  toCnt;
  logic               inFrame;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= iUartRx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  // Bit index 0 is the start-bit check at half a bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      rxBusy   <= 1'b0;
      rxCnt    <= '0;
      rxBitIdx <= '0;
      rxShift  <= '0;
      rxByte   <= '0;
      byteStb  <= 1'b0;
      frmErr   <= 1'b0;
    end else begin
      byteStb <= 1'b0;
      frmErr  <= 1'b0;
      if (!rxBusy) begin
        if (rxPrev && !rxSync) begin
          rxBusy   <= 1'b1;
          rxCnt    <= '0;
          rxBitIdx <= '0;
        end
      end else if (rxBitIdx == 4'd0) begin
        if (rxCnt == halfLast) begin
          rxCnt <= '0;
          if (rxSync) begin
            rxBusy <= 1'b0;
          end else begin
            rxBitIdx <= 4'd1;
          end
        end else begin
          rxCnt <= rxCnt + 1'b1;
        end
      end else if (rxCnt != cpbLast) begin
        rxCnt <= rxCnt + 1'b1;
      end else begin
        rxCnt <= '0;
        if (rxBitIdx == 4'd9) begin
          rxBusy <= 1'b0;
          if (rxSync) begin
            byteStb <= 1'b1;
            rxByte  <= rxShift;
          end else begin
            frmErr <= 1'b1;
          end
        end else begin
          rxShift  <= {rxSync, rxShift[7:1]};
          rxBitIdx <= rxBitIdx + 1'b1;
        end
      end
    end
  end

  assign inFrame = (state >= stCmd) && (state <= stD0);

  // Frame parser; a byte strobe takes priority over an expiring inter-byte timeout.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      state    <= stSync;
      cmdWrite <= 1'b0;
      adrs     <= '0;
      wData    <= '0;
      cmdVd    <= 1'b0;
      protErr  <= 1'b0;
      ovfErr   <= 1'b0;
      toCnt    <= '0;
    end else begin
      protErr <= 1'b0;
      ovfErr  <= 1'b0;

      if (byteStb || !inFrame) begin
        toCnt <= '0;
      end else begin
        toCnt <= toCnt + 1'b1;
      end

      if (state == stIssue) begin
        if (cmdVd && cmdBus.iCmdRdy) begin
          cmdVd <= 1'b0;
          state <= stSync;
        end
        if (byteStb) begin
          ovfErr <= 1'b1;
        end
      end else if (byteStb) begin
        case (state)
          stSync: begin
            if (rxByte == 8'hA5) begin
              state <= stCmd;
            end
          end
          stCmd: begin
            if (rxByte == 8'h01 || rxByte == 8'h02) begin
              cmdWrite <= (rxByte == 8'h01);
              wData    <= '0;
              state    <= stAh;
            end else begin
              protErr <= 1'b1;
              state   <= stSync;
            end
          end
          stAh: begin
            adrs[15:8] <= rxByte;
            state      <= stAl;
          end
          stAl: begin
            adrs[7:0] <= rxByte;
            if (cmdWrite) begin
              state <= stD3;
            end else begin
              state <= stIssue;
              cmdVd <= 1'b1;
            end
          end
          stD3, stD2, stD1: begin
            wData <= {wData[23:0], rxByte};
            state <= state + 1'b1;
          end
          stD0: begin
            wData <= {wData[23:0], rxByte};
            state <= stIssue;
            cmdVd <= 1'b1;
          end
          default: begin
            state <= stSync;
          end
        endcase
      end else if (inFrame && toCnt == toLast) begin
        protErr <= 1'b1;
        state   <= stSync;
      end
    end
  end

  // The frame always carries 16 address bits; fit them to the bus address width.
  generate
    if (pBusAdrsBit > 16) begin : gAdrsExt
      assign cmdBus.oCmdAdrs = {{(pBusAdrsBit - 16){1'b0}}, adrs};
    end else begin : gAdrsTrunc
      assign cmdBus.oCmdAdrs = adrs[pBusAdrsBit-1:0];
    end
  endgenerate

  assign cmdBus.oCmdVd    = cmdVd;
  assign cmdBus.oCmdWEd   = cmdWrite;
  assign cmdBus.oCmdWd    = wData;
  assign cmdBus.oFrmErr   = frmErr;
  assign cmdBus.oProtErr  = protErr;
  assign cmdBus.oOvfErr   = ovfErr;

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed bench for uart_cmd_receiver: CPB=10, inter-byte timeout 500 cycles.
// Inputs change 1 time unit after the rising edge; the pulse monitor samples on the falling edge.
module tb_uart_cmd_receiver;

  localparam int Cpb = 10;

  logic clk    = 1'b0;
  logic rstN   = 1'b0;
  logic uartRx = 1'b1;

  int checks = 0;
  int errors = 0;

  int xferCnt  = 0;
  int vdCycles = 0;
  int frmCnt   = 0;
  int protCnt  = 0;
  int ovfCnt   = 0;
  logic        lastWEd  = 1'b0;
  logic [15:0] lastAdrs = '0;
  logic [31:0] lastWd   = '0;

  always #5 clk = ~clk;

  uart_cmd_receiver_if #(.pBusAdrsBit(16)) cmdBus ();

  uart_cmd_receiver #(
    .pSysClkHz  (1_000_000),
    .pBaudRate  (100_000),
    .pBusAdrsBit(16),
    .pTimeoutCyc(500)
  ) dut (
    .iSysClk(clk),
    .iSysRst(rstN),
    .iUartRx(uartRx),
    .cmdBus (cmdBus)
  );

  // Counts handshakes and error pulses so short events between checks are not missed.
  always @(negedge clk) begin
    if (rstN) begin
      if (cmdBus.oCmdVd) vdCycles <= vdCycles + 1;
      if (cmdBus.oCmdVd && cmdBus.iCmdRdy) begin
        xferCnt  <= xferCnt + 1;
        lastWEd  <= cmdBus.oCmdWEd;
        lastAdrs <= cmdBus.oCmdAdrs;
        lastWd   <= cmdBus.oCmdWd;
      end
      if (cmdBus.oFrmErr)  frmCnt  <= frmCnt + 1;
      if (cmdBus.oProtErr) protCnt <= protCnt + 1;
      if (cmdBus.oOvfErr)  ovfCnt  <= ovfCnt + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit = 1'b1);
    uartRx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      tick(Cpb);
    end
    uartRx = stopBit;
    tick(Cpb);
    uartRx = 1'b1;
    if (!stopBit) tick(Cpb);
  endtask

  task automatic sendFrame(input logic [7:0] bytes [8], input int n);
    for (int i = 0; i < n; i++) applyStimulus(bytes[i]);
  endtask

  initial begin
    int x0, v0, f0, p0, o0, m;
    logic stable, seen;

    cmdBus.iCmdRdy = 1'b0;
    tick(3);
    checkOutput("resetVd",   64'(cmdBus.oCmdVd),   64'd0);
    checkOutput("resetWEd",  64'(cmdBus.oCmdWEd),  64'd0);
    checkOutput("resetAdrs", 64'(cmdBus.oCmdAdrs), 64'd0);
    checkOutput("resetWd",   64'(cmdBus.oCmdWd),   64'd0);
    checkOutput("resetErrs", 64'({cmdBus.oFrmErr, cmdBus.oProtErr, cmdBus.oOvfErr}), 64'd0);
    rstN = 1'b1;
    tick(20);

    // 1: write frame with ready already high
    $display("[TB] test 1: write frame");
    cmdBus.iCmdRdy = 1'b1;
    x0 = xferCnt; v0 = vdCycles;
    sendFrame('{8'hA5, 8'h01, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 8);
    tick(5);
    checkOutput("t1Xfer",  64'(xferCnt - x0),  64'd1);
    checkOutput("t1VdCyc", 64'(vdCycles - v0), 64'd1);
    checkOutput("t1WEd",   64'(lastWEd),       64'd1);
    checkOutput("t1Adrs",  64'(lastAdrs),      64'h1234);
    checkOutput("t1Wd",    64'(lastWd),        64'hDEADBEEF);
    checkOutput("t1VdLow", 64'(cmdBus.oCmdVd), 64'd0);

    // 2: read frame held by a stalled consumer
    $display("[TB] test 2: read frame with backpressure");
    cmdBus.iCmdRdy = 1'b0;
    x0 = xferCnt; v0 = vdCycles;
    sendFrame('{8'hA5, 8'h02, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    checkOutput("t2Vd",   64'(cmdBus.oCmdVd),   64'd1);
    checkOutput("t2WEd",  64'(cmdBus.oCmdWEd),  64'd0);
    checkOutput("t2Adrs", 64'(cmdBus.oCmdAdrs), 64'h0040);
    checkOutput("t2Wd",   64'(cmdBus.oCmdWd),   64'd0);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (cmdBus.oCmdVd !== 1'b1 || cmdBus.oCmdWEd !== 1'b0 ||
          cmdBus.oCmdAdrs !== 16'h0040 || cmdBus.oCmdWd !== 32'd0) stable = 1'b0;
    end
    checkOutput("t2Stable", 64'(stable), 64'd1);
    cmdBus.iCmdRdy = 1'b1;
    tick(1);
    checkOutput("t2VdDrop", 64'(cmdBus.oCmdVd), 64'd0);
    checkOutput("t2Xfer",   64'(xferCnt - x0),  64'd1);
    checkOutput("t2VdLong", 64'((vdCycles - v0) >= 50), 64'd1);
    checkOutput("t2XAdrs",  64'(lastAdrs), 64'h0040);

    // 3: junk bytes, then a bad command byte, then a good frame
    $display("[TB] test 3: junk and bad command");
    x0 = xferCnt; p0 = protCnt;
    sendFrame('{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    tick(5);
    checkOutput("t3NoXfer", 64'(xferCnt - x0), 64'd0);
    checkOutput("t3Prot",   64'(protCnt - p0), 64'd1);
    sendFrame('{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    tick(5);
    checkOutput("t3Xfer",  64'(xferCnt - x0), 64'd1);
    checkOutput("t3Adrs",  64'(lastAdrs),     64'hABCD);
    checkOutput("t3WEd",   64'(lastWEd),      64'd0);

    // 4: framing error and a line glitch inside a frame leave the parser untouched
    $display("[TB] test 4: framing error and glitch");
    x0 = xferCnt; p0 = protCnt; f0 = frmCnt;
    applyStimulus(8'hA5);
    applyStimulus(8'h55, 1'b0);
    uartRx = 1'b0;
    tick(1);
    uartRx = 1'b1;
    tick(20);
    sendFrame('{8'h02, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    tick(5);
    checkOutput("t4Frm",    64'(frmCnt - f0),  64'd1);
    checkOutput("t4NoProt", 64'(protCnt - p0), 64'd0);
    checkOutput("t4Xfer",   64'(xferCnt - x0), 64'd1);
    checkOutput("t4Adrs",   64'(lastAdrs),     64'h5678);

    // 5: inter-byte timeout after a partial frame
    $display("[TB] test 5: timeout");
    x0 = xferCnt; p0 = protCnt;
    sendFrame('{8'hA5, 8'h01, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    seen = 1'b0;
    m = 0;
    for (int i = 1; i <= 600; i++) begin
      tick(1);
      if (!seen && cmdBus.oProtErr) begin
        seen = 1'b1;
        m = i;
      end
    end
    checkOutput("t5Seen",   64'(seen), 64'd1);
    checkOutput("t5Window", 64'(m >= 490 && m <= 510), 64'd1);
    checkOutput("t5Prot",   64'(protCnt - p0), 64'd1);
    checkOutput("t5NoXfer", 64'(xferCnt - x0), 64'd0);
    sendFrame('{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'h01, 8'h02, 8'h03, 8'h04}, 8);
    tick(5);
    checkOutput("t5Xfer", 64'(xferCnt - x0), 64'd1);
    checkOutput("t5Adrs", 64'(lastAdrs),     64'hCAFE);
    checkOutput("t5Wd",   64'(lastWd),       64'h01020304);
    checkOutput("t5WEd",  64'(lastWEd),      64'd1);

    // 6: overflow while a command is pending, then reset mid-frame
    $display("[TB] test 6: overflow and reset");
    cmdBus.iCmdRdy = 1'b0;
    x0 = xferCnt; o0 = ovfCnt;
    sendFrame('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    applyStimulus(8'h33);
    tick(2);
    checkOutput("t6Ovf",  64'(ovfCnt - o0),     64'd1);
    checkOutput("t6Vd",   64'(cmdBus.oCmdVd),   64'd1);
    checkOutput("t6Adrs", 64'(cmdBus.oCmdAdrs), 64'h1122);
    checkOutput("t6WEd",  64'(cmdBus.oCmdWEd),  64'd0);
    cmdBus.iCmdRdy = 1'b1;
    tick(2);
    checkOutput("t6Xfer",  64'(xferCnt - x0), 64'd1);
    checkOutput("t6XAdrs", 64'(lastAdrs),     64'h1122);
    cmdBus.iCmdRdy = 1'b0;
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    f0 = frmCnt; p0 = protCnt; o0 = ovfCnt;
    uartRx = 1'b0;
    tick(35);
    rstN = 1'b0;
    #1;
    checkOutput("t6RstVd",   64'(cmdBus.oCmdVd),   64'd0);
    checkOutput("t6RstWEd",  64'(cmdBus.oCmdWEd),  64'd0);
    checkOutput("t6RstAdrs", 64'(cmdBus.oCmdAdrs), 64'd0);
    checkOutput("t6RstWd",   64'(cmdBus.oCmdWd),   64'd0);
    tick(3);
    uartRx = 1'b1;
    rstN = 1'b1;
    tick(20);
    checkOutput("t6NoErr", 64'((frmCnt - f0) + (protCnt - p0) + (ovfCnt - o0)), 64'd0);
    cmdBus.iCmdRdy = 1'b1;
    x0 = xferCnt;
    sendFrame('{8'hA5, 8'h01, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h2A}, 8);
    tick(5);
    checkOutput("t6RecXfer", 64'(xferCnt - x0), 64'd1);
    checkOutput("t6RecAdrs", 64'(lastAdrs),     64'h0008);
    checkOutput("t6RecWd",   64'(lastWd),       64'h0000002A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
